// File: rtl/rf_scoreboard.sv
// rf_scoreboard: multi-port register file with pending-write scoreboard; RF_BYPASS_EN enables write-through forwarding.
// Latency: reads combinational, writes/busy/count update at the next edge; no backpressure (decode stalls on rd_busy_o).
module rf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RegWrite_i,
  input  logic [ADDR_W-1:0]        wa_i,
  input  logic [DATA_W-1:0]        wd_i,
  input  logic [NUM_RD*ADDR_W-1:0] ra_i,
  output logic [NUM_RD*DATA_W-1:0] rd_o,
  output logic [NUM_RD-1:0]        rd_busy_o,
  input  logic                     issue_i,
  input  logic [ADDR_W-1:0]        issue_wa_i,
  input  logic                     flush_i,
  output logic [ADDR_W:0]          busy_cnt_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [ADDR_W:0]   busy_cnt_nxt;
  logic              wr_en;
  logic              iss_en;
  logic              cnt_inc;
  logic              cnt_dec;

  assign wr_en  = RegWrite_i && (wa_i != '0);
  assign iss_en = issue_i && (issue_wa_i != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa_i] <= wd_i;
    end
  end

  // Set is applied after clear so a new producer supersedes a same-cycle writeback.
  always_comb begin
    busy_nxt = busy;
    if (flush_i) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)  busy_nxt[wa_i]       = 1'b0;
      if (iss_en) busy_nxt[issue_wa_i] = 1'b1;
    end
  end

  always_comb begin
    cnt_inc      = iss_en && !busy[issue_wa_i];
    cnt_dec      = wr_en && busy[wa_i] && !(iss_en && (issue_wa_i == wa_i));
    busy_cnt_nxt = busy_cnt_o + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};
    if (flush_i) busy_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_cnt_o <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_o <= busy_cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = ra_i[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    logic fwd;
    assign fwd = rst_n && wr_en && (wa_i == ra);
    assign rd_o[k*DATA_W +: DATA_W] = fwd ? wd_i : regs[ra];
    assign rd_busy_o[k]             = busy[ra] && !fwd;
`else
    assign rd_o[k*DATA_W +: DATA_W] = regs[ra];
    assign rd_busy_o[k]             = busy[ra];
`endif
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomized scoreboard bench for rf_scoreboard against an array-based reference model.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite_i;
  logic [4:0]  wa_i;
  logic [31:0] wd_i;
  logic [9:0]  ra_i;
  logic [63:0] rd_o;
  logic [1:0]  rd_busy_o;
  logic        issue_i;
  logic [4:0]  issue_wa_i;
  logic        flush_i;
  logic [5:0]  busy_cnt_o;

  always #5 clk = ~clk;

  rf_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk(clk), .rst_n(rst_n), .RegWrite_i(RegWrite_i), .wa_i(wa_i), .wd_i(wd_i),
    .ra_i(ra_i), .rd_o(rd_o), .rd_busy_o(rd_busy_o), .issue_i(issue_i),
    .issue_wa_i(issue_wa_i), .flush_i(flush_i), .busy_cnt_o(busy_cnt_o)
  );

  typedef struct {
    int          id;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic        b0;
    logic        b1;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [5:0] model_count();
    int s = 0;
    for (int i = 0; i < 32; i++) s += int'(m_busy[i]);
    return 6'(s);
  endfunction

  function automatic logic [31:0] exp_rd(bit we, logic [4:0] wa, logic [31:0] wd, logic [4:0] r);
    logic [31:0] v;
    v = (r == 0) ? 32'h0 : m_mem[r];
`ifdef RF_BYPASS_EN
    if (we && wa != 0 && wa == r) v = wd;
`endif
    if (!rst_n) v = 32'h0;
    return v;
  endfunction

  function automatic logic exp_busy(bit we, logic [4:0] wa, logic [4:0] r);
    logic b;
    b = m_busy[r];
`ifdef RF_BYPASS_EN
    if (we && wa != 0 && wa == r) b = 1'b0;
`endif
    if (!rst_n) b = 1'b0;
    return b;
  endfunction

  // Called just after a rising edge: drive inputs, queue expected outputs, advance the model.
  task automatic cycle(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input bit iss, input logic [4:0] iwa, input bit fl);
    exp_t e;
    RegWrite_i = we; wa_i = wa; wd_i = wd; ra_i = {r1, r0};
    issue_i = iss; issue_wa_i = iwa; flush_i = fl;
    e.id  = cyc;
    e.rd0 = exp_rd(we, wa, wd, r0);
    e.rd1 = exp_rd(we, wa, wd, r1);
    e.b0  = exp_busy(we, wa, r0);
    e.b1  = exp_busy(we, wa, r1);
    e.cnt = model_count();
    q.push_back(e);
    if (rst_n) begin
      if (we && wa != 0) m_mem[wa] = wd;
      if (fl) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else begin
        if (we && wa != 0) m_busy[wa] = 1'b0;
        if (iss && iwa != 0) m_busy[iwa] = 1'b1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    cycle(1'b0, 5'd0, 32'h0, r0, r1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, id, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("rd0",   e.id, rd_o[31:0],              e.rd0);
        check("rd1",   e.id, rd_o[63:32],             e.rd1);
        check("busy0", e.id, {31'h0, rd_busy_o[0]},   {31'h0, e.b0});
        check("busy1", e.id, {31'h0, rd_busy_o[1]},   {31'h0, e.b1});
        check("cnt",   e.id, {26'h0, busy_cnt_o},     {26'h0, e.cnt});
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    RegWrite_i = 1'b0; wa_i = '0; wd_i = '0; ra_i = '0;
    issue_i = 1'b0; issue_wa_i = '0; flush_i = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    // Reads during reset, including a write attempt that must not show through.
    cycle(1'b1, 5'd3, 32'h1111_2222, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i += 2) idle(5'(i), 5'(i + 1));

    cycle(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    cycle(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd0, 1'b1, 5'd0, 1'b0);
    idle(5'd0, 5'd5);

    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 1'b1, 5'd7, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 1'b1, 5'd9, 1'b0);
    idle(5'd7, 5'd9);
    cycle(1'b1, 5'd7, 32'hA5, 5'd7, 5'd9, 1'b0, 5'd0, 1'b0);
    idle(5'd7, 5'd9);

    cycle(1'b1, 5'd3, 32'h55, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd9, 1'b1, 5'd3, 1'b0);
    cycle(1'b1, 5'd9, 32'h99, 5'd3, 5'd9, 1'b1, 5'd9, 1'b0);
    idle(5'd3, 5'd9);

    cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1, 5'd1, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1, 5'd2, 1'b0);
    cycle(1'b0, 5'd0, 32'h0, 5'd4, 5'd6, 1'b1, 5'd4, 1'b0);
    cycle(1'b1, 5'd8, 32'h88, 5'd4, 5'd6, 1'b1, 5'd6, 1'b1);
    idle(5'd6, 5'd8);

    cycle(1'b0, 5'd0, 32'h0, 5'd10, 5'd10, 1'b1, 5'd10, 1'b0);
    cycle(1'b1, 5'd10, 32'hCAFE, 5'd10, 5'd11, 1'b1, 5'd10, 1'b0);
    cycle(1'b1, 5'd10, 32'hBEEF, 5'd10, 5'd10, 1'b0, 5'd0, 1'b0);
    idle(5'd10, 5'd11);

    // Fill every register's busy bit to reach the maximum count.
    for (int i = 0; i < 32; i++) cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'd0, 1'b1, 5'(i), 1'b0);
    idle(5'd31, 5'd0);
    cycle(1'b0, 5'd0, 32'h0, 5'd31, 5'd0, 1'b1, 5'd31, 1'b0);

    for (int n = 0; n < 3000; n++) begin
      bit          narrow = ($urandom_range(0, 1) == 1);
      logic [4:0]  wa  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      logic [4:0]  iwa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      logic [4:0]  r0  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      logic [4:0]  r1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      if (n == 1500) begin
        rst_n = 1'b0;
        model_clear();
        idle(r0, r1);
        cycle(1'b1, wa, $urandom, wa, r1, 1'b1, iwa, 1'b0);
        rst_n = 1'b1;
      end
      cycle(($urandom_range(0, 2) != 0), wa, $urandom, r0, r1,
            ($urandom_range(0, 2) != 0), iwa, ($urandom_range(0, 63) == 0));
    end
    idle(5'd0, 5'd0);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected records left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
